// File: rtl/tsd_emu_pkg.sv
// Shared types, register map and encoding helper for the TSD conversion emulator.
package tsd_emu_pkg;

    localparam logic [1:0] TSD_EMU_IDLE    = 2'd0;
    localparam logic [1:0] TSD_EMU_CONVERT = 2'd1;
    localparam logic [1:0] TSD_EMU_DONE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = TSD_EMU_IDLE,
        ST_CONVERT = TSD_EMU_CONVERT,
        ST_DONE    = TSD_EMU_DONE
    } tsd_emu_state_e;

    localparam logic [1:0] TSD_EMU_REG_TARGET  = 2'd0;
    localparam logic [1:0] TSD_EMU_REG_STEP    = 2'd1;
    localparam logic [1:0] TSD_EMU_REG_CURRENT = 2'd2;
    localparam logic [1:0] TSD_EMU_REG_COUNT   = 2'd3;

    // Two's complement degC to offset binary (+128) is an MSB flip.
    function automatic logic [7:0] tsd_encode(input logic [7:0] temp);
        return {~temp[7], temp[6:0]};
    endfunction

endpackage

// File: rtl/tsd_emu_if.sv
// Avalon-MM control slave bundle for the TSD emulator.
interface tsd_emu_if;
    logic [1:0]  ctrl_mm_address;
    logic        ctrl_mm_write;
    logic [15:0] ctrl_mm_writedata;
    logic        ctrl_mm_read;
    logic [15:0] ctrl_mm_readdata;

    modport master (
        output ctrl_mm_address, ctrl_mm_write, ctrl_mm_writedata, ctrl_mm_read,
        input  ctrl_mm_readdata
    );

    modport slave (
        input  ctrl_mm_address, ctrl_mm_write, ctrl_mm_writedata, ctrl_mm_read,
        output ctrl_mm_readdata
    );
endinterface

// File: rtl/tsd_emu_ramp.sv
// Combinational ramp step: moves current toward target by at most step (0 = jump).
module tsd_emu_ramp (
    input  logic [7:0] current,
    input  logic [7:0] target,
    input  logic [7:0] step,
    output logic [7:0] next_current
);

    logic [8:0] diff;
    logic [8:0] mag;
    logic [8:0] moved;

    always_comb begin
        diff  = {target[7], target} - {current[7], current};
        mag   = diff[8] ? (9'd0 - diff) : diff;
        moved = diff[8] ? ({current[7], current} - {1'b0, step})
                        : ({current[7], current} + {1'b0, step});
        if (step == 8'd0 || mag <= {1'b0, step}) begin
            next_current = target;
        end else begin
            // |diff| > step keeps the result strictly between current and target.
            next_current = moved[7:0];
        end
    end

endmodule

// File: rtl/tsd_emu.sv
// Hard-TSD conversion emulator with Avalon-MM temperature control.
// Optional ramp feature enabled by defining TSD_EMU_RAMP_EN.
module tsd_emu
    import tsd_emu_pkg::*;
#(
    parameter int ConvCycles = 1024,
    parameter int InitTemp   = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    output logic [7:0] tsdcalo,
    output logic       tsdcaldone,
    tsd_emu_if.slave   ctrl_mm
);

    localparam int         CW        = $clog2(ConvCycles);
    localparam logic [CW-1:0] LAST   = CW'(ConvCycles - 1);
    localparam logic [7:0] INIT_TEMP = 8'(InitTemp);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    target_q;
    logic [7:0]    cur_q;
    logic [7:0]    step_q;
    logic [7:0]    next_cur;
    logic [15:0]   count_q;
    logic [15:0]   rdata;
    logic          latch;
    logic          wr_target;
    logic          wr_count;
    logic          unused_wdata_hi;

    assign unused_wdata_hi = ^ctrl_mm.ctrl_mm_writedata[15:8];

    assign latch     = (state == TSD_EMU_CONVERT) && !clr && (cnt == LAST);
    assign wr_target = ctrl_mm.ctrl_mm_write && (ctrl_mm.ctrl_mm_address == TSD_EMU_REG_TARGET);
    assign wr_count  = ctrl_mm.ctrl_mm_write && (ctrl_mm.ctrl_mm_address == TSD_EMU_REG_COUNT);

`ifdef TSD_EMU_RAMP_EN
    logic wr_step;
    assign wr_step = ctrl_mm.ctrl_mm_write && (ctrl_mm.ctrl_mm_address == TSD_EMU_REG_STEP);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step_q <= '0;
        end else if (wr_step) begin
            step_q <= ctrl_mm.ctrl_mm_writedata[7:0];
        end
    end

    tsd_emu_ramp u_ramp (
        .current      (cur_q),
        .target       (target_q),
        .step         (step_q),
        .next_current (next_cur)
    );
`else
    assign step_q   = '0;
    assign next_cur = target_q;
`endif

    // Conversion FSM and result outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= TSD_EMU_IDLE;
            cnt        <= '0;
            tsdcaldone <= 1'b0;
            tsdcalo    <= tsd_encode(INIT_TEMP);
            cur_q      <= INIT_TEMP;
        end else begin
            case (state)
                TSD_EMU_IDLE: begin
                    cnt        <= '0;
                    tsdcaldone <= 1'b0;
                    if (!clr) begin
                        state <= TSD_EMU_CONVERT;
                    end
                end
                TSD_EMU_CONVERT: begin
                    if (clr) begin
                        state <= TSD_EMU_IDLE;
                        cnt   <= '0;
                    end else if (latch) begin
                        state      <= TSD_EMU_DONE;
                        cnt        <= '0;
                        tsdcaldone <= 1'b1;
                        cur_q      <= next_cur;
                        tsdcalo    <= tsd_encode(next_cur);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TSD_EMU_DONE: begin
                    if (clr) begin
                        state      <= TSD_EMU_IDLE;
                        tsdcaldone <= 1'b0;
                    end
                end
                default: begin
                    state      <= TSD_EMU_IDLE;
                    cnt        <= '0;
                    tsdcaldone <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (ctrl_mm.ctrl_mm_address)
            TSD_EMU_REG_TARGET:  rdata = {8'h00, target_q};
            TSD_EMU_REG_STEP:    rdata = {8'h00, step_q};
            TSD_EMU_REG_CURRENT: rdata = {8'h00, cur_q};
            TSD_EMU_REG_COUNT:   rdata = count_q;
            default:             rdata = '0;
        endcase
    end

    // Register file; the latch samples target before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target_q                 <= INIT_TEMP;
            count_q                  <= '0;
            ctrl_mm.ctrl_mm_readdata <= '0;
        end else begin
            if (wr_target) begin
                target_q <= ctrl_mm.ctrl_mm_writedata[7:0];
            end
            if (wr_count) begin
                count_q <= '0;
            end else if (latch) begin
                count_q <= count_q + 16'd1;
            end
            if (ctrl_mm.ctrl_mm_read) begin
                ctrl_mm.ctrl_mm_readdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_tsd_emu.sv
// Directed self-checking bench for tsd_emu (ConvCycles=16, InitTemp=25).
module tb_tsd_emu;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tsdcalo;
    logic       tsdcaldone;

    int n_vec = 0;
    int n_err = 0;

    tsd_emu_if bus ();

    tsd_emu #(.ConvCycles(16), .InitTemp(25)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr),
        .tsdcalo    (tsdcalo),
        .tsdcaldone (tsdcaldone),
        .ctrl_mm    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
        bus.ctrl_mm_address   = a;
        bus.ctrl_mm_writedata = d;
        bus.ctrl_mm_write     = 1'b1;
        tick();
        bus.ctrl_mm_write     = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [15:0] d);
        bus.ctrl_mm_address = a;
        bus.ctrl_mm_read    = 1'b1;
        tick();
        bus.ctrl_mm_read    = 1'b0;
        d = bus.ctrl_mm_readdata;
    endtask

    // Drop clr, wait for done (17 edges expected), check result, optionally release.
    task automatic run_conv(input string tag, input logic [7:0] exp_calo, input bit hold);
        int lat;
        lat = -1;
        clr = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (tsdcaldone) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_latency"}, lat, 17);
        check_eq({tag, "_calo"}, tsdcalo, exp_calo);
        if (!hold) begin
            clr = 1'b1;
            tick();
            check_eq({tag, "_done_fall"}, tsdcaldone, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr     = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  exp_t;
        logic        saw_done;
        logic [7:0]  step_exp;

`ifdef TSD_EMU_RAMP_EN
        step_exp = 8'd10;
`else
        step_exp = 8'd0;
`endif
        bus.ctrl_mm_address   = '0;
        bus.ctrl_mm_write     = 1'b0;
        bus.ctrl_mm_writedata = '0;
        bus.ctrl_mm_read      = 1'b0;

        // Reset values
        reset_n = 1'b0;
        clr     = 1'b1;
        repeat (3) tick();
        check_eq("rst_calo", tsdcalo, 8'd153);
        check_eq("rst_done", tsdcaldone, 1'b0);
        check_eq("rst_readdata", bus.ctrl_mm_readdata, 16'h0000);
        reset_n = 1'b1;
        tick();
        reg_rd(2'd3, rd);
        check_eq("rst_count", rd, 16'h0000);

        // First conversion at InitTemp
        run_conv("conv1", 8'd153, 1'b0);
        reg_rd(2'd3, rd);
        check_eq("count_after_1", rd, 16'h0001);

        // Read and write of TARGET in the same cycle returns the old value
        bus.ctrl_mm_address   = 2'd0;
        bus.ctrl_mm_writedata = 16'h0050;
        bus.ctrl_mm_write     = 1'b1;
        bus.ctrl_mm_read      = 1'b1;
        tick();
        bus.ctrl_mm_write     = 1'b0;
        bus.ctrl_mm_read      = 1'b0;
        check_eq("rw_same_old", bus.ctrl_mm_readdata, 16'h0019);
        reg_rd(2'd0, rd);
        check_eq("target_80", rd, 16'h0050);
        reg_wr(2'd1, 16'h0000);
        run_conv("jump80", 8'd208, 1'b0);
        check_eq("fan_trip", tsdcalo > 8'd198, 1'b1);
        reg_rd(2'd3, rd);
        check_eq("count_after_2", rd, 16'h0002);

        // Ramp toward 40 with STEP=10
        do_reset();
        reg_wr(2'd0, 16'h0028);
        reg_wr(2'd1, 16'h000A);
        reg_wr(2'd2, 16'h0077);
        reg_rd(2'd1, rd);
        check_eq("step_read", rd, {8'h00, step_exp});
`ifdef TSD_EMU_RAMP_EN
        run_conv("ramp_up1", 8'd163, 1'b0);
`else
        run_conv("ramp_up1", 8'd168, 1'b0);
`endif
        run_conv("ramp_up2", 8'd168, 1'b0);
        run_conv("ramp_up3", 8'd168, 1'b0);
        reg_rd(2'd2, rd);
        check_eq("current_40", rd[7:0], 8'd40);

        // Ramp down to -128; upper write bits must read back as 0
        reg_wr(2'd0, 16'hFF80);
        reg_rd(2'd0, rd);
        check_eq("target_m128", rd, 16'h0080);
        exp_t = 8'd40;
        for (int k = 0; k < 18; k++) begin
`ifdef TSD_EMU_RAMP_EN
            if ($signed(exp_t) - 10 < -128) exp_t = 8'h80;
            else exp_t = exp_t - 8'd10;
`else
            exp_t = 8'h80;
`endif
            run_conv("ramp_down", exp_t ^ 8'h80, 1'b0);
        end
        check_eq("ramp_floor", tsdcalo, 8'h00);
        reg_rd(2'd3, rd);
        check_eq("count_21", rd, 16'd21);

        // Abort at cycle 8
        clr = 1'b0;
        repeat (8) tick();
        clr = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            saw_done = saw_done | tsdcaldone;
        end
        check_eq("abort_no_done", saw_done, 1'b0);
        check_eq("abort_calo", tsdcalo, 8'h00);
        reg_rd(2'd3, rd);
        check_eq("abort_count", rd, 16'd21);

        // Hold in DONE, then reset
        run_conv("hold", 8'h00, 1'b1);
        repeat (5) tick();
        check_eq("done_hold", tsdcaldone, 1'b1);
        reset_n = 1'b0;
        clr     = 1'b1;
        tick();
        check_eq("rst_done_drop", tsdcaldone, 1'b0);
        check_eq("rst_calo2", tsdcalo, 8'd153);
        reset_n = 1'b1;
        tick();
        reg_rd(2'd0, rd);
        check_eq("rst_target", rd, 16'h0019);
        reg_rd(2'd1, rd);
        check_eq("rst_step", rd, 16'h0000);
        reg_rd(2'd2, rd);
        check_eq("rst_current", rd[7:0], 8'd25);
        reg_rd(2'd3, rd);
        check_eq("rst_count2", rd, 16'h0000);

        // COUNT wrap and clear
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        reg_rd(2'd3, rd);
        check_eq("count_ffff", rd, 16'hFFFF);
        run_conv("wrap", 8'd153, 1'b0);
        reg_rd(2'd3, rd);
        check_eq("count_wrap", rd, 16'h0000);
        run_conv("post_wrap", 8'd153, 1'b0);
        reg_rd(2'd3, rd);
        check_eq("count_one", rd, 16'h0001);
        reg_wr(2'd3, 16'h1234);
        reg_rd(2'd3, rd);
        check_eq("count_clear", rd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
